// File: rtl/shared_memory_arbiter.sv
// Merges the core's instruction and data ports onto one single-port memory bus.
// The data port has priority. A starvation counter lets an instruction request
// through after STARVE_LIMIT back-to-back data grants.
// Optional feature macro: ARB_PERF_COUNT_EN adds per-port stall-cycle counters.
module shared_memory_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_busy,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
`ifdef ARB_PERF_COUNT_EN
  ,
  output logic [31:0]         i_stall_cnt,
  output logic [31:0]         d_stall_cnt
`endif
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ACC  = 3'd1,
    D_ACC  = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  // Instruction port has waited through the allowed number of data grants
  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Busy drops only in the served port's DONE cycle; no request means not busy
  assign i_busy = i_req & (state != I_DONE);
  assign d_busy = d_req & (state != D_DONE);

  // Arbitration FSM with registered memory-bus outputs and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !(i_req && starved)) begin
            state     <= D_ACC;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_we ? d_be : {BE_W{1'b1}};
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!i_req) begin
              starve_cnt <= '0;
            end else if (!starved) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end else if (i_req) begin
            state      <= I_ACC;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_be     <= {BE_W{1'b1}};
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        I_ACC: begin
          if (mem_ack) begin
            i_rdata <= mem_rdata;
            mem_req <= 1'b0;
            state   <= I_DONE;
          end
        end
        D_ACC: begin
          if (mem_ack) begin
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            mem_req <= 1'b0;
            state   <= D_DONE;
          end
        end
        I_DONE:  state <= IDLE;
        D_DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_COUNT_EN
  // Stall-cycle counters, one per port, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      i_stall_cnt <= '0;
      d_stall_cnt <= '0;
    end else begin
      if (i_busy) i_stall_cnt <= i_stall_cnt + 32'd1;
      if (d_busy) d_stall_cnt <= d_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shared_memory_arbiter.sv
// Directed bench for shared_memory_arbiter: a behavioural memory answers the
// bus, a scoreboard queue holds the expected grant order and bus contents.
module tb_shared_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_busy;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_busy;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef ARB_PERF_COUNT_EN
  logic [31:0] i_stall_cnt;
  logic [31:0] d_stall_cnt;
`endif

  shared_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_busy(d_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef ARB_PERF_COUNT_EN
    , .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   lat = 2;
  bit   inject_ack = 1'b0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] wd);
    txn_t t;
    t.we = we; t.be = be; t.addr = a; t.wdata = we ? wd : 32'h0;
    sb.push_back(t);
  endtask

  // Waits for the port's busy to drop; n counts the busy cycles seen before it
  task automatic wait_low(input bit port_d, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((port_d ? d_busy : i_busy) == 1'b0) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
  endtask

  // Memory model: acks lat cycles after mem_req rises, data derived from address
  initial begin
    int rsp_cnt;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    rsp_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (inject_ack) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        rsp_cnt = 0;
      end else if (mem_req && !mem_ack) begin
        rsp_cnt++;
        if (rsp_cnt > lat) begin
          mem_ack = 1'b1;
          mem_rdata = rd_word(mem_addr);
          rsp_cnt = 0;
        end
      end else begin
        mem_ack = 1'b0;
        rsp_cnt = 0;
      end
    end
  end

  // Scoreboard: every completed bus access must match the next expected grant
  always @(negedge clk) begin
    if (!reset && mem_req && mem_ack) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_access", {31'h0, mem_ack}, 64'h0);
      end else begin
        txn_t e;
        e = sb.pop_front();
        chk("sb_we_be_addr", {27'h0, mem_we, mem_be, mem_addr}, {27'h0, e.we, e.be, e.addr});
        if (e.we) chk("sb_wdata", {32'h0, mem_wdata}, {32'h0, e.wdata});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;
    int d_cnt;
    bit got;
`ifdef ARB_PERF_COUNT_EN
    logic [31:0] i_sc0;
`endif
    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_mem_req", {63'h0, mem_req}, 64'h0);
    chk("reset_i_rdata", {32'h0, i_rdata}, 64'h0);
    chk("reset_d_rdata", {32'h0, d_rdata}, 64'h0);
    chk("reset_busy", {62'h0, i_busy, d_busy}, 64'h0);
    chk("reset_mem_bus", {27'h0, mem_we, mem_be, mem_addr}, 64'h0);

`ifdef ARB_PERF_COUNT_EN
    // 3-cycle-latency instruction read: five stall cycles on the I port only
    lat = 3;
    i_sc0 = i_stall_cnt;
    push(1'b0, 4'hF, 32'h0000_0020, 32'h0);
    @(posedge clk); #2;
    i_req = 1'b1; i_addr = 32'h0000_0020;
    wait_low(1'b0, n, ok);
    chk("perf_done", {63'h0, ok}, 64'h1);
    chk("perf_i_stall", {32'h0, i_stall_cnt - i_sc0}, 64'd5);
    chk("perf_d_stall", {32'h0, d_stall_cnt}, 64'd0);
    @(posedge clk); #2;
    i_req = 1'b0;
`endif

    // Instruction read, memory acks 2 cycles after mem_req
    lat = 2;
    push(1'b0, 4'hF, 32'h0000_0100, 32'h0);
    @(posedge clk); #2;
    i_req = 1'b1; i_addr = 32'h0000_0100;
    wait_low(1'b0, n, ok);
    chk("iread_done", {63'h0, ok}, 64'h1);
    chk("iread_busy_cycles", 64'(n), 64'd4);
    chk("iread_rdata", {32'h0, i_rdata}, {32'h0, rd_word(32'h100)});
    chk("iread_done_mem_req", {63'h0, mem_req}, 64'h0);
    @(posedge clk); #2;
    i_req = 1'b0;

    // Data read, 1-cycle memory latency
    lat = 1;
    push(1'b0, 4'hF, 32'h0000_0080, 32'h0);
    @(posedge clk); #2;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080; d_be = 4'h0;
    wait_low(1'b1, n, ok);
    chk("dread_done", {63'h0, ok}, 64'h1);
    chk("dread_busy_cycles", 64'(n), 64'd3);
    chk("dread_rdata", {32'h0, d_rdata}, {32'h0, rd_word(32'h80)});
    @(posedge clk); #2;
    d_req = 1'b0;

    // Simultaneous requests: data write wins, instruction follows
    lat = 2;
    push(1'b1, 4'b0011, 32'h0000_0040, 32'hDEAD_BEEF);
    push(1'b0, 4'hF, 32'h0000_0200, 32'h0);
    @(posedge clk); #2;
    i_req = 1'b1; i_addr = 32'h0000_0200;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h0000_0040; d_wdata = 32'hDEAD_BEEF;
    wait_low(1'b1, n, ok);
    chk("both_d_done", {63'h0, ok}, 64'h1);
    chk("both_i_still_busy", {63'h0, i_busy}, 64'h1);
    chk("both_write_keeps_d_rdata", {32'h0, d_rdata}, {32'h0, rd_word(32'h80)});
    @(posedge clk); #2;
    d_req = 1'b0; d_we = 1'b0;
    wait_low(1'b0, n, ok);
    chk("both_i_done", {63'h0, ok}, 64'h1);
    chk("both_i_rdata", {32'h0, i_rdata}, {32'h0, rd_word(32'h200)});
    chk("both_d_rdata_after", {32'h0, d_rdata}, {32'h0, rd_word(32'h80)});
    @(posedge clk); #2;
    i_req = 1'b0;

    // Starvation: four data grants, then one instruction grant, then data again
    lat = 1;
    repeat (4) push(1'b0, 4'hF, 32'h0000_0300, 32'h0);
    push(1'b0, 4'hF, 32'h0000_0400, 32'h0);
    push(1'b0, 4'hF, 32'h0000_0300, 32'h0);
    @(posedge clk); #2;
    i_req = 1'b1; i_addr = 32'h0000_0400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    d_cnt = 0;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (d_req && !d_busy) d_cnt++;
      if (!i_busy) begin
        got = 1'b1;
        break;
      end
    end
    chk("starve_i_served", {63'h0, got}, 64'h1);
    chk("starve_d_before_i", 64'(d_cnt), 64'd4);
    chk("starve_i_rdata", {32'h0, i_rdata}, {32'h0, rd_word(32'h400)});
    @(posedge clk); #2;
    i_req = 1'b0;
    wait_low(1'b1, n, ok);
    chk("starve_d_resumes", {63'h0, ok}, 64'h1);
    chk("starve_d_rdata", {32'h0, d_rdata}, {32'h0, rd_word(32'h300)});
    @(posedge clk); #2;
    d_req = 1'b0;

    // Write request dropped one cycle after grant still completes on the bus
    lat = 3;
    push(1'b1, 4'b1100, 32'h0000_0044, 32'h1234_5678);
    @(posedge clk); #2;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b1100; d_addr = 32'h0000_0044; d_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("drop_busy_before", {63'h0, d_busy}, 64'h1);
    @(posedge clk); #2;
    d_req = 1'b0; d_wdata = 32'hFFFF_FFFF; d_addr = 32'h0000_0FFC; d_be = 4'h0;
    @(negedge clk);
    chk("drop_busy_now", {63'h0, d_busy}, 64'h0);
    chk("drop_mem_req_held", {62'h0, mem_req, mem_we}, 64'h3);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mem_ack) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("drop_ack_seen", {63'h0, got}, 64'h1);
    @(negedge clk);
    chk("drop_mem_req_released", {63'h0, mem_req}, 64'h0);
    chk("drop_d_rdata_kept", {32'h0, d_rdata}, {32'h0, rd_word(32'h300)});
    chk("drop_sb_drained", 64'(sb.size()), 64'd0);
    d_we = 1'b0;

    // Reset during I_ACC with a late ack arriving in the following cycle
    lat = 10;
    @(posedge clk); #2;
    i_req = 1'b1; i_addr = 32'h0000_0500;
    @(posedge clk); #2;
    reset = 1'b1; i_req = 1'b0; inject_ack = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_acc", {63'h0, mem_req}, 64'h1);
    @(posedge clk); #2;
    reset = 1'b0; inject_ack = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rst_mid_rdata", {i_rdata, d_rdata}, 64'h0);
    chk("rst_mid_mem_bus", {27'h0, mem_we, mem_be, mem_addr}, 64'h0);
    chk("rst_mid_wdata", {32'h0, mem_wdata}, 64'h0);
    @(negedge clk);
    chk("rst_late_ack_ignored", {32'h0, i_rdata}, 64'h0);
    chk("rst_late_mem_req", {62'h0, mem_req, i_busy}, 64'h0);
    @(negedge clk);
    chk("rst_stays_idle", {63'h0, mem_req}, 64'h0);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
